uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter: memory-mapped write port feeding a FIFO, serialised onto TxD.

---
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter: bus write port -> FIFO -> framed serial output on TxD.
// Optional parity bit when UART_TX_PARITY_EN is defined (PARITY_ODD selects odd parity).
module uart_tx_fifo #(
    parameter int DATA_W        = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int STOP_BITS     = 1,
    parameter int TICKS_PER_BIT = 16,
    parameter int PARITY_ODD    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          iocs,
    input  logic                          iorw,
    input  logic [1:0]                    ioaddr,
    input  logic [DATA_W-1:0]             databus,
    output logic                          TxD,
    output logic                          tbr,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              ODD       = 1'(PARITY_ODD);
`ifdef UART_TX_PARITY_EN
    localparam logic HAS_PARITY = 1'b1;
`else
    localparam logic HAS_PARITY = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              txd_q;

    logic push_req, push_ok, full, pop, bit_done, frame_done;

    assign push_req   = iocs && !iorw && (ioaddr == 2'b00);
    assign full       = (count == FULL_CNT);
    assign bit_done   = enable && (tick_cnt == TICK_LAST);
    assign frame_done = (state == S_STOP) && bit_done && (bit_cnt == STOP_LAST);
    // A frame ending with data queued starts the next one in the same cycle (no idle gap).
    assign pop        = (count != '0) && ((state == S_IDLE) || frame_done);
    assign push_ok    = push_req && (!full || pop);

    assign TxD        = txd_q;
    assign tbr        = !full;
    assign tx_busy    = (state != S_IDLE);
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= databus;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push_req && !push_ok;
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            txd_q    <= 1'b1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else if (pop) begin
            state    <= S_START;
            txd_q    <= 1'b0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= mem[rd_ptr];
            par_bit  <= (^mem[rd_ptr]) ^ ODD;
        end else if (enable && (state != S_IDLE)) begin
            if (!bit_done) begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end else begin
                tick_cnt <= '0;
                case (state)
                    S_START: begin
                        state   <= S_DATA;
                        txd_q   <= shreg[0];
                        bit_cnt <= '0;
                    end
                    S_DATA: begin
                        if (bit_cnt == DATA_LAST) begin
                            state   <= HAS_PARITY ? S_PARITY : S_STOP;
                            txd_q   <= HAS_PARITY ? par_bit : 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shreg   <= shreg >> 1;
                            txd_q   <= shreg[1];
                        end
                    end
                    S_PARITY: begin
                        state   <= S_STOP;
                        txd_q   <= 1'b1;
                        bit_cnt <= '0;
                    end
                    S_STOP: begin
                        if (bit_cnt == STOP_LAST) state <= S_IDLE;
                        else bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                    default: begin
                        state <= S_IDLE;
                        txd_q <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default instance plus a STOP_BITS=2 instance on a slow baud tick.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst, enable, enable2, iocs, iocs2, iorw;
    logic [1:0] ioaddr;
    logic [7:0] databus;
    logic       txd, tbr, tx_busy, overflow;
    logic [2:0] fifo_count;
    logic       txd2, tbr2, tx_busy2, overflow2;
    logic [2:0] fifo_count2;
    int         tests = 0;
    int         fails = 0;
    int         ph = 0;
    logic [7:0] exp_q[$];

    uart_tx_fifo dut (
        .clk(clk), .rst(rst), .enable(enable), .iocs(iocs), .iorw(iorw),
        .ioaddr(ioaddr), .databus(databus), .TxD(txd), .tbr(tbr),
        .tx_busy(tx_busy), .fifo_count(fifo_count), .overflow(overflow)
    );

    uart_tx_fifo #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .iocs(iocs2), .iorw(iorw),
        .ioaddr(ioaddr), .databus(databus), .TxD(txd2), .tbr(tbr2),
        .tx_busy(tx_busy2), .fifo_count(fifo_count2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    // Slow baud tick for dut2: one pulse every third clock.
    initial begin
        enable2 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            enable2 = (ph == 2);
            ph = (ph + 1) % 3;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; databus = d;
        cyc(1);
        iocs = 1'b0;
    endtask

    task automatic write2(input logic [7:0] d);
        iocs2 = 1'b1; iorw = 1'b0; ioaddr = 2'b00; databus = d;
        cyc(1);
        iocs2 = 1'b0;
    endtask

    // Called at the start-bit edge (minus skip cycles already spent); returns at mid last stop bit.
    task automatic recv_frame(input int skip, output logic [7:0] d, output logic start_ok,
                              output logic par, output logic stop_ok);
        cyc(8 - skip);
        start_ok = (txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(16);
            d[i] = txd;
        end
        par = 1'b0;
`ifdef UART_TX_PARITY_EN
        cyc(16);
        par = txd;
`endif
        cyc(16);
        stop_ok = (txd === 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(3);
        tests++;
        if ({txd, tbr, tx_busy, fifo_count, overflow} !== 7'b1_1_0_000_0) begin
            $display("FAIL reset_state: got %b required 1100000", {txd, tbr, tx_busy, fifo_count, overflow});
            fails++;
        end
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_ignored;
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; databus = 8'hFF;
        cyc(1);
        iorw = 1'b0; ioaddr = 2'b01;
        cyc(1);
        iocs = 1'b0; ioaddr = 2'b00;
        cyc(2);
        tests++;
        if ({txd, tx_busy, fifo_count, overflow} !== 6'b1_0_000_0) begin
            $display("FAIL ignored_access: got %b required 100000", {txd, tx_busy, fifo_count, overflow});
            fails++;
        end
    endtask

    task automatic test_single;
        logic [7:0] d;
        logic so, p, st;
        write(8'hA5);
        tests++;
        if ({fifo_count, txd, tx_busy} !== 5'b001_1_0) begin
            $display("FAIL single_after_write: got %b required 00110", {fifo_count, txd, tx_busy});
            fails++;
        end
        cyc(1);
        tests++;
        if ({fifo_count, txd, tx_busy} !== 5'b000_0_1) begin
            $display("FAIL single_start_latency: got %b required 00001", {fifo_count, txd, tx_busy});
            fails++;
        end
        recv_frame(0, d, so, p, st);
        tests++;
        if ({so, d, st} !== {1'b1, 8'hA5, 1'b1}) begin
            $display("FAIL single_frame: got start=%b data=%h stop=%b required 1 a5 1", so, d, st);
            fails++;
        end
        cyc(7);
        tests++;
        if ({tx_busy, txd} !== 2'b11) begin
            $display("FAIL single_stop_hold: got busy,txd=%b required 11", {tx_busy, txd});
            fails++;
        end
        cyc(1);
        tests++;
        if ({tx_busy, txd} !== 2'b01) begin
            $display("FAIL single_end: got busy,txd=%b required 01", {tx_busy, txd});
            fails++;
        end
        cyc(3);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] d;
        logic so, p, st;
        logic [7:0] vals [2];
        logic       pars [2];
        vals[0] = 8'hA5; pars[0] = 1'b0;
        vals[1] = 8'h01; pars[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            write(vals[k]);
            cyc(1);
            recv_frame(0, d, so, p, st);
            tests++;
            if ({d, p, st} !== {vals[k], pars[k], 1'b1}) begin
                $display("FAIL parity_frame_%0d: got data=%h par=%b stop=%b required %h %b 1", k, d, p, st, vals[k], pars[k]);
                fails++;
            end
            cyc(8);
            tests++;
            if (tx_busy !== 1'b0) begin
                $display("FAIL parity_length_%0d: busy=%b after 11 bits, required 0", k, tx_busy);
                fails++;
            end
            cyc(2);
        end
    endtask
`endif

    task automatic test_fifo_full;
        logic [7:0] d, e;
        logic so, p, st;
        write(8'h3C);
        cyc(1);
        write(8'h11);
        write(8'h22);
        write(8'h33);
        tests++;
        if ({tbr, fifo_count} !== 4'b1_011) begin
            $display("FAIL full_three: got tbr,count=%b required 1011", {tbr, fifo_count});
            fails++;
        end
        write(8'h44);
        tests++;
        if ({tbr, fifo_count, overflow} !== 5'b0_100_0) begin
            $display("FAIL full_four: got tbr,count,ovf=%b required 01000", {tbr, fifo_count, overflow});
            fails++;
        end
        write(8'h55);
        tests++;
        if ({overflow, fifo_count} !== 4'b1_100) begin
            $display("FAIL overflow_pulse: got ovf,count=%b required 1100", {overflow, fifo_count});
            fails++;
        end
        cyc(1);
        tests++;
        if (overflow !== 1'b0) begin
            $display("FAIL overflow_width: got %b required 0", overflow);
            fails++;
        end
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
        recv_frame(6, d, so, p, st);
        tests++;
        if ({so, d, st} !== {1'b1, 8'h3C, 1'b1}) begin
            $display("FAIL full_first_frame: got start=%b data=%h stop=%b required 1 3c 1", so, d, st);
            fails++;
        end
        cyc(7);
        write(8'h66);
        tests++;
        if ({fifo_count, overflow, txd, tbr} !== 6'b100_0_0_0) begin
            $display("FAIL full_push_pop: got count,ovf,txd,tbr=%b required 100000", {fifo_count, overflow, txd, tbr});
            fails++;
        end
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            recv_frame(0, d, so, p, st);
            tests++;
            if ({so, d, st} !== {1'b1, e, 1'b1}) begin
                $display("FAIL queued_frame_%0d: got start=%b data=%h stop=%b required 1 %h 1", i, so, d, st, e);
                fails++;
            end
            cyc(8);
            tests++;
            if (i < 4 && (txd !== 1'b0 || tx_busy !== 1'b1)) begin
                $display("FAIL no_gap_%0d: got txd,busy=%b required 01", i, {txd, tx_busy});
                fails++;
            end else if (i == 4 && {tx_busy, fifo_count, txd} !== 5'b0_000_1) begin
                $display("FAIL drain_end: got busy,count,txd=%b required 00001", {tx_busy, fifo_count, txd});
                fails++;
            end
        end
        cyc(3);
    endtask

    task automatic test_slow_two_stop;
        logic prev;
        int   n, tend, iv;
        int   tt[12];
        logic done;
        write2(8'h55);
        prev = txd2; n = 0; tend = 0; done = 1'b0;
        for (int c = 1; c <= 1500 && !done; c++) begin
            cyc(1);
            if (txd2 !== prev) begin
                if (n < 12) tt[n] = c;
                n++;
                prev = txd2;
            end
            if (tx_busy2 !== 1'b1) begin
                done = 1'b1;
                tend = c;
            end
        end
        tests++;
        if (!done || n != 10) begin
            $display("FAIL slow_transitions: done=%b edges=%0d required done=1 edges=10", done, n);
            fails++;
        end else begin
            tests++;
            if (tt[1] - tt[0] < 46 || tt[1] - tt[0] > 48) begin
                $display("FAIL slow_start_bit: got %0d clk required 46..48", tt[1] - tt[0]);
                fails++;
            end
            for (int k = 1; k <= 8; k++) begin
                iv = 48;
`ifdef UART_TX_PARITY_EN
                if (k == 8) iv = 96;
`endif
                tests++;
                if (tt[k+1] - tt[k] != iv) begin
                    $display("FAIL slow_bit_%0d: got %0d clk required %0d", k, tt[k+1] - tt[k], iv);
                    fails++;
                end
            end
            tests++;
            if (tend - tt[9] != 96) begin
                $display("FAIL slow_stop_len: got %0d clk required 96", tend - tt[9]);
                fails++;
            end
        end
        cyc(3);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        logic so, p, st;
        write(8'hC3);
        cyc(1);
        write(8'h5A);
        cyc(71);
        tests++;
        if ({txd, tx_busy, fifo_count} !== 5'b0_1_001) begin
            $display("FAIL pre_reset_bit3: got txd,busy,count=%b required 01001", {txd, tx_busy, fifo_count});
            fails++;
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({txd, tbr, tx_busy, fifo_count} !== 6'b1_1_0_000) begin
            $display("FAIL async_reset: got txd,tbr,busy,count=%b required 110000", {txd, tbr, tx_busy, fifo_count});
            fails++;
        end
        cyc(2);
        rst = 1'b0;
        cyc(20);
        tests++;
        if ({txd, tx_busy, fifo_count} !== 5'b1_0_000) begin
            $display("FAIL reset_discard: got txd,busy,count=%b required 10000", {txd, tx_busy, fifo_count});
            fails++;
        end
        write(8'h96);
        cyc(1);
        recv_frame(0, d, so, p, st);
        tests++;
        if ({so, d, st} !== {1'b1, 8'h96, 1'b1}) begin
            $display("FAIL post_reset_frame: got start=%b data=%h stop=%b required 1 96 1", so, d, st);
            fails++;
        end
        cyc(8);
        tests++;
        if (tx_busy !== 1'b0) begin
            $display("FAIL post_reset_end: busy=%b required 0", tx_busy);
            fails++;
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; iocs = 1'b0; iocs2 = 1'b0;
        iorw = 1'b0; ioaddr = 2'b00; databus = 8'h00;
        test_reset();
        test_ignored();
        test_single();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_fifo_full();
        test_slow_two_stop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
